// File: rtl/data_l1_cache.sv
// Direct-mapped write-allocate L1 data cache, one word per line, with independent read/write ports.
// Latency: 1 cycle, all outputs registered; no backpressure (always accepts, a read miss returns zero).
module data_l1_cache #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] WriteAddress_Full,
  input  logic [DATA_W-1:0] WriteValue,
  input  logic [ADDR_W-1:0] ReadAddress_Full,
  output logic [DATA_W-1:0] ReadValue,
  output logic              WriteHit,
  output logic              ReadHit,
  input  logic              write,
  input  logic              read
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } lineT;

  logic [LINES-1:0] lineValid;
  lineT             lines [LINES];

  logic [INDEX_W-1:0] writeIndex, readIndex;
  logic [TAG_W-1:0]   writeTag, readTag;
  logic               writeMatch, readMatch;

  assign writeIndex = WriteAddress_Full[INDEX_W-1:0];
  assign writeTag   = WriteAddress_Full[ADDR_W-1:INDEX_W];
  assign readIndex  = ReadAddress_Full[INDEX_W-1:0];
  assign readTag    = ReadAddress_Full[ADDR_W-1:INDEX_W];

  // The valid bit gates both compares so never-written lines cannot produce an X hit.
  assign writeMatch = lineValid[writeIndex] && (lines[writeIndex].tag == writeTag);
  assign readMatch  = lineValid[readIndex] && (lines[readIndex].tag == readTag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lineValid <= '0;
      ReadValue <= '0;
      ReadHit   <= 1'b0;
      WriteHit  <= 1'b0;
    end else begin
      WriteHit <= write && writeMatch;
      if (write) begin
        lineValid[writeIndex] <= 1'b1;
      end
      ReadHit <= read && readMatch;
      if (read) begin
        ReadValue <= readMatch ? lines[readIndex].data : '0;
      end
    end
  end

  // Tag/data storage needs no reset; a stale entry is harmless once its valid bit is clear.
  always_ff @(posedge clk) begin
    if (write) begin
      lines[writeIndex] <= '{tag: writeTag, data: WriteValue};
    end
  end

endmodule

// File: tb/tb_data_l1_cache.sv
// Scoreboard bench for data_l1_cache: a reference cache model pushes expected outputs per driven edge.
module tb_data_l1_cache;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int INDEX_W = 4;
  localparam int LINES   = 1 << INDEX_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] WriteAddress_Full;
  logic [DATA_W-1:0] WriteValue;
  logic [ADDR_W-1:0] ReadAddress_Full;
  logic [DATA_W-1:0] ReadValue;
  logic              WriteHit;
  logic              ReadHit;
  logic              write;
  logic              read;

  data_l1_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .WriteAddress_Full(WriteAddress_Full),
    .WriteValue(WriteValue),
    .ReadAddress_Full(ReadAddress_Full),
    .ReadValue(ReadValue),
    .WriteHit(WriteHit),
    .ReadHit(ReadHit),
    .write(write),
    .read(read)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              readHit;
    logic [DATA_W-1:0] readValue;
    logic              writeHit;
  } expT;

  expT expQ[$];

  logic                      mValid [LINES];
  logic [ADDR_W-INDEX_W-1:0] mTag   [LINES];
  logic [DATA_W-1:0]         mData  [LINES];
  logic [DATA_W-1:0]         mLastRv;

  int testCount = 0;
  int failCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
    mLastRv = '0;
  endtask

  // Drive one edge, predict its outputs into the scoreboard, then compare after the edge.
  task automatic doCycle(input logic wr, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wv,
                         input logic rd, input logic [ADDR_W-1:0] ra);
    expT e;
    int wi, ri;
    logic [ADDR_W-INDEX_W-1:0] wt, rt;
    @(negedge clk);
    write = wr; WriteAddress_Full = wa; WriteValue = wv;
    read = rd;  ReadAddress_Full = ra;
    wi = int'(wa[INDEX_W-1:0]); wt = wa[ADDR_W-1:INDEX_W];
    ri = int'(ra[INDEX_W-1:0]); rt = ra[ADDR_W-1:INDEX_W];
    e.readHit   = rd && mValid[ri] && (mTag[ri] == rt);
    e.readValue = rd ? (e.readHit ? mData[ri] : '0) : mLastRv;
    e.writeHit  = wr && mValid[wi] && (mTag[wi] == wt);
    mLastRv = e.readValue;
    if (wr) begin
      mValid[wi] = 1'b1; mTag[wi] = wt; mData[wi] = wv;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkVal("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkVal("ReadHit", 32'(ReadHit), 32'(e.readHit));
      checkVal("ReadValue", 32'(ReadValue), 32'(e.readValue));
      checkVal("WriteHit", 32'(WriteHit), 32'(e.writeHit));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    write = 1'b0; read = 1'b0;
    WriteAddress_Full = '0; WriteValue = '0; ReadAddress_Full = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_ReadValue", 32'(ReadValue), 32'd0);
    checkVal("rst_ReadHit", 32'(ReadHit), 32'd0);
    checkVal("rst_WriteHit", 32'(WriteHit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty cache read, allocate, then read-before-write visibility.
    doCycle(1'b0, 16'd0, 16'd0, 1'b1, 16'd0);
    doCycle(1'b1, 16'd0, 16'd23, 1'b1, 16'd0);
    checkVal("alloc_rd_before_wr", 32'(ReadHit), 32'd0);
    doCycle(1'b0, 16'd0, 16'd0, 1'b1, 16'd0);
    checkVal("plan_rd0_23", 32'(ReadValue), 32'd23);
    doCycle(1'b1, 16'd0, 16'd31, 1'b0, 16'd0);
    checkVal("plan_whit0", 32'(WriteHit), 32'd1);
    doCycle(1'b0, 16'd0, 16'd0, 1'b1, 16'd0);
    checkVal("plan_rd0_31", 32'(ReadValue), 32'd31);

    doCycle(1'b1, 16'd1, 16'd42, 1'b1, 16'd0);
    doCycle(1'b1, 16'd2, 16'd51, 1'b1, 16'd0);
    doCycle(1'b0, 16'd0, 16'd0, 1'b1, 16'd1);
    checkVal("plan_rd1_42", 32'(ReadValue), 32'd42);
    doCycle(1'b0, 16'd0, 16'd0, 1'b1, 16'd2);
    checkVal("plan_rd2_51", 32'(ReadValue), 32'd51);
    // read=0 must hold ReadValue while clearing ReadHit.
    doCycle(1'b0, 16'd0, 16'd0, 1'b0, 16'd5);
    checkVal("hold_rv", 32'(ReadValue), 32'd51);

    // Conflict eviction via aliasing address 0x13 onto index 3.
    doCycle(1'b1, 16'd3, 16'd62, 1'b0, 16'd0);
    doCycle(1'b1, 16'h13, 16'd77, 1'b0, 16'd0);
    checkVal("plan_evict_whit", 32'(WriteHit), 32'd0);
    doCycle(1'b0, 16'd0, 16'd0, 1'b1, 16'd3);
    checkVal("plan_evict_rhit", 32'(ReadHit), 32'd0);
    doCycle(1'b0, 16'd0, 16'd0, 1'b1, 16'h13);
    checkVal("plan_rd13_77", 32'(ReadValue), 32'd77);

    // Mixed traffic over a few tags per index to exercise hits, misses and evictions.
    for (int n = 0; n < 300; n++) begin
      logic [ADDR_W-1:0] wa, ra;
      wa = ADDR_W'(($urandom_range(0, 2) << INDEX_W) | $urandom_range(0, LINES - 1));
      ra = ADDR_W'(($urandom_range(0, 2) << INDEX_W) | $urandom_range(0, LINES - 1));
      if (n % 7 == 0) ra = wa;
      doCycle(1'($urandom_range(0, 1)), wa, DATA_W'($urandom), 1'($urandom_range(0, 3) != 0), ra);
    end

    // Asynchronous reset between edges, held across an edge with a write pending.
    doCycle(1'b1, 16'd1, 16'd99, 1'b1, 16'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkVal("arst_ReadValue", 32'(ReadValue), 32'd0);
    checkVal("arst_ReadHit", 32'(ReadHit), 32'd0);
    checkVal("arst_WriteHit", 32'(WriteHit), 32'd0);
    @(negedge clk);
    write = 1'b1; WriteAddress_Full = 16'd1; WriteValue = 16'd5;
    @(posedge clk);
    #1;
    checkVal("arst_hold_rv", 32'(ReadValue), 32'd0);
    @(negedge clk);
    write = 1'b0;
    rst_n = 1'b1;
    modelReset();
    doCycle(1'b0, 16'd0, 16'd0, 1'b1, 16'd1);
    checkVal("plan_post_rst_miss", 32'(ReadHit), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_l1_cache.md
Name: data_l1_cache

Overview:
- Level-1 data cache: direct-mapped, write-allocate, one 16-bit word per line.
- Has one independent write port and one independent read port, both serviced on the same clock edge.
- Reports a hit/miss flag for each port. There is no next-level interface; a read miss returns zero and a write miss allocates the line.
- Sits between the CPU load/store unit and the (future) L2; hit flags let the pipeline decide whether to stall.

Parameters:
- ADDR_W, 16, full address width in bits.
- DATA_W, 16, word width in bits.
- INDEX_W, 4, index bits; the cache holds 2^INDEX_W lines (16 by default). Tag width is ADDR_W-INDEX_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- WriteAddress_Full  input  ADDR_W  word address for the write port.
- WriteValue  input  DATA_W  data to store.
- ReadAddress_Full  input  ADDR_W  word address for the read port.
- ReadValue  output  DATA_W  registered read data.
- WriteHit  output  1  registered; 1 = the last write found a valid matching line.
- ReadHit  output  1  registered; 1 = the last read found a valid matching line.
- write  input  1  write enable, sampled at the rising edge.
- read  input  1  read enable, sampled at the rising edge.

Behaviour:
- Address split:
  - index = address[INDEX_W-1:0] (low bits).
  - tag = remaining upper bits.
- Per-line state: valid bit, tag, data word.
- Reset (rst_n low, asynchronous):
  - All valid bits cleared.
  - ReadValue=0, ReadHit=0, WriteHit=0.
  - Tag and data contents need not be cleared.
  - Reset asserted mid-operation aborts any pending update; the first edge after release operates on an empty cache.
- Write, on the rising edge with write=1:
  - hit = valid[index] && tag[index]==write tag.
  - WriteHit <= hit.
  - Line is updated in both cases: data <= WriteValue, tag <= write tag, valid <= 1. On a hit the data is overwritten; on a miss the line is allocated and the old line silently evicted (no write-back).
- write=0: WriteHit <= 0; no array change.
- Read, on the rising edge with read=1:
  - hit evaluated against the array state before this edge.
  - Hit: ReadValue <= stored data, ReadHit <= 1.
  - Miss: ReadValue <= 0, ReadHit <= 0; no allocation on a read miss.
- read=0: ReadHit <= 0; ReadValue holds its previous value.
- Latency:
  - One cycle: outputs reflect the inputs sampled at the previous rising edge.
  - Outputs are stable between edges and never combinational from inputs.
- Simultaneous read and write to the same index on one edge:
  - The read sees pre-edge contents (read-before-write).
  - The written value is visible to a read on the next edge.
- Same index, different tag: the write evicts the line; a read on the following edge of the old tag misses.
- Address wrap: addresses differing only above bit INDEX_W-1 alias to the same line and are distinguished solely by tag.
- No X propagation: the valid bit gates every hit decision, so unwritten lines always miss.

Test Plan:
- Reset, then read addr 0 with read=1, write=0 -> ReadHit=0, ReadValue=0, WriteHit=0.
- Write addr 0 / 23 while reading addr 0 on one edge -> WriteHit=0 (allocate), ReadHit=0. Next edge, read addr 0 -> ReadHit=1, ReadValue=23.
- Write addr 0 / 31 (line valid) -> WriteHit=1. Next edge, read addr 0 -> ReadValue=31.
- Sequence:
  - Write addr1/42, then addr2/51 while reading addr 0 -> WriteHit=0 each time.
  - Then read addr1 -> ReadHit=1, ReadValue=42.
  - Then read addr2 -> ReadHit=1, ReadValue=51.
- Conflict eviction:
  - Write addr 3 / 62, then addr 19 (0x13, same index 3) / 77 -> second write WriteHit=0.
  - Then read addr 3 -> ReadHit=0, ReadValue=0.
  - Then read addr 19 -> ReadHit=1, ReadValue=77.
- Assert rst_n low asynchronously between edges after filling lines -> outputs go to 0 immediately. After release, read addr 1 -> ReadHit=0.
